// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  // Width of the per-stage control bundle that a bubble clears.
  localparam int unsigned CTRL_W = 9;

  // Register $zero never creates a dependency.
  localparam logic [4:0] REG0 = 5'd0;

  // Sequencer state encoding.
  typedef logic [1:0] state_t;
  localparam state_t RUN      = 2'd0;
  localparam state_t LU_STALL = 2'd1;
  localparam state_t FREEZE   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc until every bit is set, then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory
// freeze and branch flush, with saturating event counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             exmem_flush,
  output logic             memwb_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Bubbles still owed after the first one.
  localparam logic [2:0] STALL_INIT = 3'(LOAD_USE_STALLS - 1);

  state_t     state_q, state_d;
  state_t     eff_state;
  logic [2:0] remain_q, remain_d;
  logic       pending_q, pending_d;
  logic       hazard, freeze_cond, branch_any;
  logic       stall_inc, freeze_inc, flush_inc;

  assign hazard = idex_mem_read && (idex_rt != REG0) &&
                  ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  assign freeze_cond = dmem_req & ~dmem_ready;
  assign branch_any  = branch_taken | pending_q;

  // On the cycle a freeze lifts, behave as the state it interrupted.
  assign eff_state = (state_q == FREEZE) ? ((remain_q != 3'd0) ? LU_STALL : RUN) : state_q;

  // Prioritised control decode: freeze, then branch, then load-use.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    exmem_flush = 1'b0;
    memwb_hold  = 1'b0;
    state_d     = state_q;
    remain_d    = remain_q;
    pending_d   = pending_q;
    stall_inc   = 1'b0;
    freeze_inc  = 1'b0;
    flush_inc   = 1'b0;
    if (!reset) begin
      if (freeze_cond) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
        memwb_hold = 1'b1;
        state_d    = FREEZE;
        freeze_inc = 1'b1;
        if (branch_taken) pending_d = 1'b1;
      end else if (branch_any) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
        pending_d   = 1'b0;
        remain_d    = 3'd0;
        state_d     = RUN;
        flush_inc   = 1'b1;
      end else if (eff_state == LU_STALL) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        remain_d    = remain_q - 3'd1;
        state_d     = (remain_q > 3'd1) ? LU_STALL : RUN;
        stall_inc   = 1'b1;
      end else if (hazard) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        remain_d    = STALL_INIT;
        state_d     = (STALL_INIT != 3'd0) ? LU_STALL : RUN;
        stall_inc   = 1'b1;
      end else begin
        state_d = RUN;
      end
    end
  end

  // Sequencer state, owed-bubble count and deferred branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      remain_q  <= 3'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      pending_q <= pending_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze_inc),
    .count (freeze_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
